// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, request bundle and byte-lane mapping.
// Lane 0 is the most significant byte (big-endian).
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  typedef struct packed {
    logic              write;
    logic              byte_op;
    logic [1:0]        lane;
    logic [WORD_W-1:0] data;
    logic              err;
  } mem_req_t;

  function automatic int lane_lsb(
    input logic [1:0] lane
  );
    int lsb;
    unique case (lane)
      2'd0: lsb = LANE0_LSB;
      2'd1: lsb = LANE1_LSB;
      2'd2: lsb = LANE2_LSB;
      2'd3: lsb = LANE3_LSB;
    endcase
    return lsb;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [1:0] lane
  );
    return 4'(1 << (lane_lsb(lane) / 8));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: MemRead/MemWrite strobe bus between the
// control unit (master) and the memory responder (slave).
interface mem_responder_if
  import mem_pkg::*;
();

  logic              MemRead;
  logic              MemWrite;
  logic              mem_byte;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              mem_ready;
  logic              mem_busy;

  modport master (
    output MemRead,
    output MemWrite,
    output mem_byte,
    output addr,
    output wdata,
    input  rdata,
    input  mem_ready,
    input  mem_busy
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  mem_byte,
    input  addr,
    input  wdata,
    output rdata,
    output mem_ready,
    output mem_busy
  );

endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 single-port RAM with byte write enables
// and a registered, read-enabled output port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic                     re,
  input  logic [3:0]               we,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        q
);

  logic [WORD_W-1:0] ram [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        ram[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (re) begin
      q <= ram[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: IDLE/BUSY/DONE target for MemRead/MemWrite strobes.
// Define MEM_ADDR_CHECK_EN for the sticky addr_err port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic           addr_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mem_state_e        state;
  mem_state_e        state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  mem_req_t          req;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     live_idx;
  logic              accept;
  logic              live_err;
  logic              cur_err;
  logic              rd_zero;
  logic [AW-1:0]     arr_idx;
  logic              arr_re;
  logic [3:0]        arr_we;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_q;

  assign live_idx = bus.addr[AW+1:2];
  assign accept   = (state == MEM_IDLE)
                  && (bus.MemRead || bus.MemWrite);

`ifdef MEM_ADDR_CHECK_EN
  assign live_err = (|bus.addr[WORD_W-1:AW+2])
                  || ((bus.addr[1:0] != 2'b00)
                  && !(bus.MemWrite && bus.mem_byte));
`else
  logic unused_hi;
  assign live_err  = 1'b0;
  assign unused_hi = ^bus.addr[WORD_W-1:AW+2];
`endif

  // With no wait states the read is issued on the accept edge.
  assign cur_err = (state == MEM_IDLE) ? live_err : req.err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MEM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    arr_idx = req_idx;
    arr_re  = 1'b0;
    arr_we  = 4'b0000;
    unique case (state)
      MEM_IDLE: begin
        arr_idx = live_idx;
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_n = MEM_BUSY;
            cnt_n   = WS_LOAD;
          end else begin
            state_n = MEM_DONE;
            arr_re  = !bus.MemWrite;
          end
        end
      end
      MEM_BUSY: begin
        if (cnt == 4'd0) begin
          state_n = MEM_DONE;
          arr_re  = !req.write;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      MEM_DONE: begin
        state_n = MEM_IDLE;
        if (req.write && !req.err) begin
          arr_we = req.byte_op
                 ? lane_be(req.lane)
                 : 4'b1111;
        end
      end
      default: state_n = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req     <= '0;
      req_idx <= '0;
    end else if (accept) begin
      req.write   <= bus.MemWrite;
      req.byte_op <= bus.mem_byte;
      req.lane    <= bus.addr[1:0];
      req.data    <= bus.wdata;
      req.err     <= live_err;
      req_idx     <= live_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_zero <= 1'b0;
    end else if (arr_re) begin
      rd_zero <= cur_err;
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (state_n == MEM_DONE
              && state != MEM_DONE
              && cur_err) begin
      addr_err <= 1'b1;
    end
  end
`endif

  assign arr_wdata = req.byte_op
                   ? {4{req.data[7:0]}}
                   : req.data;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .idx   (arr_idx),
    .re    (arr_re),
    .we    (arr_we),
    .wdata (arr_wdata),
    .q     (arr_q)
  );

  assign bus.rdata     = rd_zero ? '0 : arr_q;
  assign bus.mem_ready = (state == MEM_DONE);
  assign bus.mem_busy  = (state != MEM_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (0 and 3 wait states) driven with
// directed and random accesses against a word-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 256;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        mr [2];
  logic        mw [2];
  logic        mb [2];
  logic [31:0] ma [2];
  logic [31:0] mwd [2];
  logic        rdy [2];
  logic        busy [2];
  logic [31:0] rdat [2];
  logic        aerr [2];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  assign bus0.MemRead  = mr[0];
  assign bus0.MemWrite = mw[0];
  assign bus0.mem_byte = mb[0];
  assign bus0.addr     = ma[0];
  assign bus0.wdata    = mwd[0];
  assign rdy[0]        = bus0.mem_ready;
  assign busy[0]       = bus0.mem_busy;
  assign rdat[0]       = bus0.rdata;
  assign bus1.MemRead  = mr[1];
  assign bus1.MemWrite = mw[1];
  assign bus1.mem_byte = mb[1];
  assign bus1.addr     = ma[1];
  assign bus1.wdata    = mwd[1];
  assign rdy[1]        = bus1.mem_ready;
  assign busy[1]       = bus1.mem_busy;
  assign rdat[1]       = bus1.rdata;

`ifdef MEM_ADDR_CHECK_EN
  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .addr_err(aerr[0]));
  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .addr_err(aerr[1]));
`else
  assign aerr[0] = 1'b0;
  assign aerr[1] = 1'b0;
  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
`endif

  // Reference model: one word array per DUT plus last read value.
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];
  bit          sticky [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input int d, input bit rd, input bit wr, input bit by,
    input logic [31:0] a, input logic [31:0] wd);
    int unsigned idx;
    int unsigned lane;
    int unsigned sh;
    bit err;
    idx  = (a / 4) % DEPTH;
    lane = a % 4;
    err  = CHK && ((a / 4 >= DEPTH) || (lane != 0 && !(wr && by)));
    if (err) sticky[d] = 1'b1;
    if (wr) begin
      if (!err) begin
        if (by) begin
          sh = 8 * (3 - lane);
          mdl[d][idx] = (mdl[d][idx] & ~(32'hFF << sh))
                      | ({24'h0, wd[7:0]} << sh);
        end else begin
          mdl[d][idx] = wd;
        end
      end
    end else if (rd) begin
      last_rd[d] = err ? 32'h0 : mdl[d][idx];
    end
    return last_rd[d];
  endfunction

  task automatic access(input int d, input bit rd, input bit wr,
                        input bit by, input logic [31:0] a,
                        input logic [31:0] wd, input int spur_at);
    logic [31:0] e;
    int lat;
    bit all_busy;
    e = model(d, rd, wr, by, a, wd);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    mr[d] = rd; mw[d] = wr; mb[d] = by;
    ma[d] = a;  mwd[d] = wd;
    @(posedge clk);
    @(negedge clk);
    mr[d] = 1'b0; mw[d] = 1'b0;
    lat = 1;
    all_busy = 1'b1;
    while (1) begin
      if (lat == spur_at) begin
        mr[d] = 1'b0; mw[d] = 1'b1; mb[d] = 1'b0;
        ma[d] = 32'h10; mwd[d] = 32'h0;
      end else if (lat == spur_at + 1) begin
        mw[d] = 1'b0;
      end
      all_busy &= busy[d];
      if (rdy[d] || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    chk(rdy[d] && lat == ws_of(d) + 1, "latency",
        32'(lat), 32'(ws_of(d) + 1));
    chk(all_busy, "busy_during", {31'h0, all_busy}, 32'h1);
    @(negedge clk);
    mr[d] = 1'b0; mw[d] = 1'b0;
    chk(!busy[d] && !rdy[d], "idle_after",
        {30'h0, busy[d], rdy[d]}, 32'h0);
  endtask

  task automatic monitor(input int d);
    logic [31:0] e;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      chk(1'b0, "unexpected_ready", rdat[d], 32'h0);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk(rdat[d] === e, "rdata", rdat[d], e);
      chk(aerr[d] === sticky[d], "addr_err",
          {31'h0, aerr[d]}, {31'h0, sticky[d]});
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rdy[0]) monitor(0);
      if (rdy[1]) monitor(1);
    end
  end

  task automatic reset_checks();
    for (int d = 0; d < 2; d++) begin
      chk(rdy[d] === 1'b0 && busy[d] === 1'b0, "reset_flags",
          {30'h0, rdy[d], busy[d]}, 32'h0);
      chk(rdat[d] === 32'h0, "reset_rdata", rdat[d], 32'h0);
      chk(aerr[d] === 1'b0, "reset_err", {31'h0, aerr[d]}, 32'h0);
    end
  endtask

  task automatic abort_write(input logic [31:0] a,
                             input logic [31:0] wd);
    mr[1] = 1'b0; mw[1] = 1'b1; mb[1] = 1'b0;
    ma[1] = a;    mwd[1] = wd;
    @(posedge clk);
    @(negedge clk);
    mw[1] = 1'b0;
    chk(busy[1] === 1'b1, "abort_busy", {31'h0, busy[1]}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 32'h0;
      sticky[d]  = 1'b0;
    end
  endtask

  initial begin
    int unsigned op;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 0; mw[d] = 0; mb[d] = 0; ma[d] = 0; mwd[d] = 0;
      last_rd[d] = 0; sticky[d] = 0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    reset = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        access(d, 0, 1, 0, 32'(i * 4), $urandom, 0);

    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0);
      access(d, 1, 0, 0, 32'h10, 32'h0, 0);
      chk(rdat[d] === 32'hDEADBEEF, "wr_rd", rdat[d], 32'hDEADBEEF);
      access(d, 0, 1, 0, 32'h00, 32'h11223344, 0);
      access(d, 0, 1, 1, 32'h01, 32'h000000AA, 0);
      access(d, 1, 0, 0, 32'h00, 32'h0, 0);
      chk(rdat[d] === 32'h11AA3344, "byte_lane", rdat[d], 32'h11AA3344);
      access(d, 0, 1, 0, 32'h20, 32'd5, 0);
      access(d, 0, 1, 0, 32'h24, 32'd9, 0);
      access(d, 1, 0, 0, 32'h20, 32'h0, 0);
      access(d, 1, 0, 0, 32'h24, 32'h0, 0);
      access(d, 0, 1, 0, 32'h20, 32'd9, 0);
      access(d, 0, 1, 0, 32'h24, 32'd5, 0);
      access(d, 1, 0, 0, 32'h20, 32'h0, 0);
      chk(rdat[d] === 32'd9, "xchg_a", rdat[d], 32'd9);
      access(d, 1, 0, 0, 32'h24, 32'h0, 0);
      chk(rdat[d] === 32'd5, "xchg_b", rdat[d], 32'd5);
    end

    // Strobes during BUSY and in the DONE->IDLE edge must be dropped.
    access(1, 1, 0, 0, 32'h24, 32'h0, 2);
    access(0, 1, 0, 0, 32'h24, 32'h0, 1);
    for (int d = 0; d < 2; d++) begin
      access(d, 1, 0, 0, 32'h10, 32'h0, 0);
      chk(rdat[d] === 32'hDEADBEEF, "spur_ignored",
          rdat[d], 32'hDEADBEEF);
    end

    access(0, 1, 1, 0, 32'h08, 32'h55, 0);
    chk(rdat[0] === 32'hDEADBEEF, "collide_rdata",
        rdat[0], 32'hDEADBEEF);
    access(0, 1, 0, 0, 32'h08, 32'h0, 0);
    chk(rdat[0] === 32'h55, "collide_write", rdat[0], 32'h55);

    abort_write(32'h10, 32'h12345678);
    access(1, 1, 0, 0, 32'h10, 32'h0, 0);
    chk(rdat[1] === 32'hDEADBEEF, "abort_kept", rdat[1], 32'hDEADBEEF);

`ifdef MEM_ADDR_CHECK_EN
    access(0, 1, 0, 0, 32'h06, 32'h0, 0);
    chk(rdat[0] === 32'h0 && aerr[0] === 1'b1, "misalign_rd",
        rdat[0], 32'h0);
    access(1, 0, 1, 0, 32'h4000, 32'hCAFEF00D, 0);
    access(1, 1, 0, 0, 32'h0, 32'h0, 0);
    chk(rdat[1] === 32'h11AA3344 && aerr[1] === 1'b1, "upper_wr",
        rdat[1], 32'h11AA3344);
`endif

    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        op = $urandom % 4;
        a  = 32'($urandom % DEPTH) * 4 + 32'($urandom % 4);
        if ($urandom % 6 == 0) a = a | (32'($urandom) << 10);
        if ($urandom % 3 != 0 && op == 0) a = a & 32'h3FC;
        unique case (op)
          0: access(d, 1, 0, 0, a, 32'h0, 0);
          1: access(d, 0, 1, 0, a, $urandom, 0);
          2: access(d, 0, 1, 1, a, $urandom, 0);
          default: access(d, 1, 1, $urandom % 2, a, $urandom, 0);
        endcase
      end
    end

    for (int d = 0; d < 2; d++) begin
      chk((d == 0 ? q0.size() : q1.size()) == 0, "queue_drained",
          32'(d == 0 ? q0.size() : q1.size()), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
